// File: rtl/timer_multi.sv
// Memory-mapped 64-bit machine timer: prescaled mtime, NumCmp one-shot or
// auto-reload compare channels with sticky pending bits, one level interrupt.
module timer_multi #(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned AddressWidth  = 32,
  parameter int unsigned NumCmp        = 4,
  parameter int unsigned PrescaleWidth = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    timer_req_i,
  input  logic [AddressWidth-1:0] timer_addr_i,
  input  logic                    timer_we_i,
  input  logic [DataWidth/8-1:0]  timer_be_i,
  input  logic [DataWidth-1:0]    timer_wdata_i,
  output logic                    timer_rvalid_o,
  output logic [DataWidth-1:0]    timer_rdata_o,
  output logic                    timer_err_o,
  output logic                    timer_intr_o
);

  if (DataWidth != 32) begin : g_bad_data_width
    $error("timer_multi: DataWidth must be 32");
  end
  if (NumCmp < 1 || NumCmp > 16) begin : g_bad_num_cmp
    $error("timer_multi: NumCmp must be in 1..16");
  end
  if (PrescaleWidth < 1 || PrescaleWidth > 16) begin : g_bad_prescale
    $error("timer_multi: PrescaleWidth must be in 1..16");
  end

  function automatic logic [31:0] merge(input logic [31:0] old_val,
                                        input logic [31:0] new_val,
                                        input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  logic [63:0]                    mtime_q, mtime_d, mtime_inc;
  logic                           en_q, en_d;
  logic [PrescaleWidth-1:0]       prescale_q, prescale_d, pre_cnt_q, pre_cnt_d;
  logic [NumCmp-1:0]              pending_q, pending_d, enable_q, enable_d, match;
  logic [NumCmp-1:0][63:0]        cmp_q, cmp_d;
  logic [NumCmp-1:0][31:0]        period_q, period_d;
  logic                           intr_q, rvalid_q, err_q;
  logic [DataWidth-1:0]           rdata_q;

  logic [9:0]                     a;
  logic                           sel_mlo, sel_mhi, sel_ctrl, sel_ist, sel_ien;
  logic [NumCmp-1:0]              sel_clo, sel_chi, sel_per;
  logic                           mapped, wr, tick;
  logic [31:0]                    bmask, wmask, ctrl_rd, ctrl_new, pend_ext, ena_ext, ena_new, rdata_n;
  logic                           unused_addr;

  assign a           = timer_addr_i[9:0];
  assign unused_addr = ^{timer_addr_i[AddressWidth-1:10], timer_addr_i[1:0]};

  always_comb begin
    sel_mlo  = (a[9:2] == 8'h00);
    sel_mhi  = (a[9:2] == 8'h01);
    sel_ctrl = (a[9:2] == 8'h02);
    sel_ist  = (a[9:2] == 8'h03);
    sel_ien  = (a[9:2] == 8'h04);
    sel_clo  = '0;
    sel_chi  = '0;
    sel_per  = '0;
    for (int unsigned i = 0; i < NumCmp; i++) begin
      sel_clo[i] = (a[9:8] == 2'b01) && (a[7:3] == 5'(i)) && !a[2];
      sel_chi[i] = (a[9:8] == 2'b01) && (a[7:3] == 5'(i)) &&  a[2];
      sel_per[i] = (a[9:8] == 2'b10) && (a[7:2] == 6'(i));
    end
    mapped = sel_mlo | sel_mhi | sel_ctrl | sel_ist | sel_ien
           | (|sel_clo) | (|sel_chi) | (|sel_per);
    wr     = timer_req_i & timer_we_i & mapped;

    for (int unsigned b = 0; b < 4; b++) bmask[8*b +: 8] = {8{timer_be_i[b]}};
    wmask = timer_wdata_i & bmask;

    ctrl_rd                         = '0;
    ctrl_rd[0]                      = en_q;
    ctrl_rd[8 +: PrescaleWidth]     = prescale_q;
    ctrl_new                        = merge(ctrl_rd, timer_wdata_i, bmask);
    pend_ext                        = '0;
    pend_ext[NumCmp-1:0]            = pending_q;
    ena_ext                         = '0;
    ena_ext[NumCmp-1:0]             = enable_q;
    ena_new                         = merge(ena_ext, timer_wdata_i, bmask);

    rdata_n = '0;
    if (sel_mlo)  rdata_n = mtime_q[31:0];
    if (sel_mhi)  rdata_n = mtime_q[63:32];
    if (sel_ctrl) rdata_n = ctrl_rd;
    if (sel_ist)  rdata_n = pend_ext;
    if (sel_ien)  rdata_n = ena_ext;
    for (int unsigned i = 0; i < NumCmp; i++) begin
      rdata_n = rdata_n | (sel_clo[i] ? cmp_q[i][31:0]  : '0)
                        | (sel_chi[i] ? cmp_q[i][63:32] : '0)
                        | (sel_per[i] ? period_q[i]     : '0);
    end
  end

  // Unwritten bytes of a written MTIME half keep the post-tick value; no carry
  // crosses between halves on a write.
  always_comb begin
    tick      = en_q && (pre_cnt_q == prescale_q);
    mtime_inc = mtime_q + {63'b0, tick};
    mtime_d   = mtime_inc;
    if (wr && sel_mlo) mtime_d[31:0]  = merge(mtime_inc[31:0],  timer_wdata_i, bmask);
    if (wr && sel_mhi) mtime_d[63:32] = merge(mtime_inc[63:32], timer_wdata_i, bmask);

    en_d       = en_q;
    prescale_d = prescale_q;
    pre_cnt_d  = pre_cnt_q;
    if (wr && sel_ctrl) begin
      en_d       = ctrl_new[0];
      prescale_d = ctrl_new[8 +: PrescaleWidth];
      pre_cnt_d  = '0;
    end else if (tick) begin
      pre_cnt_d  = '0;
    end else if (en_q) begin
      pre_cnt_d  = pre_cnt_q + PrescaleWidth'(1);
    end

    enable_d = (wr && sel_ien) ? ena_new[NumCmp-1:0] : enable_q;

    for (int unsigned i = 0; i < NumCmp; i++) begin
      match[i]    = (mtime_q >= cmp_q[i]);
      cmp_d[i]    = (match[i] && (period_q[i] != '0)) ? cmp_q[i] + {32'b0, period_q[i]}
                                                      : cmp_q[i];
      if (wr && sel_clo[i]) cmp_d[i][31:0]  = merge(cmp_d[i][31:0],  timer_wdata_i, bmask);
      if (wr && sel_chi[i]) cmp_d[i][63:32] = merge(cmp_d[i][63:32], timer_wdata_i, bmask);
      period_d[i] = (wr && sel_per[i]) ? merge(period_q[i], timer_wdata_i, bmask) : period_q[i];
    end

    pending_d = (pending_q & ~((wr && sel_ist) ? wmask[NumCmp-1:0] : '0)) | match;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime_q    <= '0;
      en_q       <= 1'b1;
      prescale_q <= '0;
      pre_cnt_q  <= '0;
      pending_q  <= '0;
      enable_q   <= '1;
      cmp_q      <= '1;
      period_q   <= '0;
      intr_q     <= 1'b0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      mtime_q    <= mtime_d;
      en_q       <= en_d;
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      cmp_q      <= cmp_d;
      period_q   <= period_d;
      intr_q     <= |(pending_d & enable_d);
      rvalid_q   <= timer_req_i;
      if (timer_req_i) begin
        err_q   <= ~mapped;
        rdata_q <= (mapped && !timer_we_i) ? rdata_n : '0;
      end
    end
  end

  assign timer_rvalid_o = rvalid_q;
  assign timer_rdata_o  = rdata_q;
  assign timer_err_o    = err_q;
  assign timer_intr_o   = intr_q;

endmodule

// File: tb/tb_timer_multi.sv
// Directed bench for timer_multi: bus timing, prescaler, one-shot and periodic
// channels, mtime carry, byte enables, error decode and mid-transfer reset.
module tb_timer_multi;
  localparam int unsigned NumCmp = 4;

  localparam logic [31:0] MTIME_LO = 32'h000, MTIME_HI = 32'h004, CTRL = 32'h008;
  localparam logic [31:0] INTR_ST  = 32'h00C, INTR_EN  = 32'h010;
  localparam logic [31:0] CMP_LO0  = 32'h100, CMP_HI0  = 32'h104;
  localparam logic [31:0] CMP_LO1  = 32'h108, CMP_HI1  = 32'h10C;
  localparam logic [31:0] CMP_LO2  = 32'h110, CMP_HI2  = 32'h114;
  localparam logic [31:0] PERIOD0  = 32'h200, PERIOD1  = 32'h204;

  logic        clk_i = 1'b0;
  logic        rst_ni, req, we, rvalid, err, intr;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  logic [31:0] rsp_data, v0, v1;
  logic        rsp_valid, rsp_err;
  int unsigned vectors = 0, miscompares = 0;

  timer_multi #(
    .DataWidth(32), .AddressWidth(32), .NumCmp(NumCmp), .PrescaleWidth(8)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .timer_req_i(req), .timer_addr_i(addr),
    .timer_we_i(we), .timer_be_i(be), .timer_wdata_i(wdata),
    .timer_rvalid_o(rvalid), .timer_rdata_o(rdata), .timer_err_o(err),
    .timer_intr_o(intr)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic w, input logic [31:0] ad, input logic [31:0] d,
                     input logic [3:0] b);
    @(negedge clk_i);
    req = 1'b1; we = w; addr = ad; wdata = d; be = b;
    @(posedge clk_i); #1;
    req = 1'b0; we = 1'b0;
    rsp_valid = rvalid; rsp_data = rdata; rsp_err = err;
  endtask

  task automatic rd(input logic [31:0] ad);
    bus(1'b0, ad, 32'h0, 4'hF);
  endtask

  task automatic wr(input logic [31:0] ad, input logic [31:0] d);
    bus(1'b1, ad, d, 4'hF);
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    step(3);
    check("rst_rvalid", rvalid, 0);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 0);
    check("rst_intr", intr, 0);
    @(negedge clk_i); rst_ni = 1'b1;

    // Free-running count and response timing
    rd(MTIME_LO); v0 = rsp_data;
    check("rd1_rvalid", rsp_valid, 1);
    check("rd1_err", rsp_err, 0);
    step(9);
    rd(MTIME_LO); v1 = rsp_data;
    check("rd2_rvalid", rsp_valid, 1);
    check("mtime_delta10", v1 - v0, 10);
    step(1);
    check("rvalid_drop", rvalid, 0);

    // Prescaler 3 -> one tick per 4 cycles, then freeze
    wr(CTRL, 32'h0000_0301);
    check("wr_rvalid", rsp_valid, 1);
    check("wr_rdata0", rsp_data, 0);
    check("wr_err0", rsp_err, 0);
    rd(MTIME_LO); v0 = rsp_data;
    step(39);
    rd(MTIME_LO); v1 = rsp_data;
    check("presc3_delta", v1 - v0, 10);
    wr(CTRL, 32'h0000_0300);
    rd(MTIME_LO); v0 = rsp_data;
    step(19);
    rd(MTIME_LO); v1 = rsp_data;
    check("frozen_delta", v1 - v0, 0);
    rd(CTRL);
    check("ctrl_rd", rsp_data, 32'h0000_0300);
    wr(CTRL, 32'h0000_0001);

    // One-shot channel 0
    wr(INTR_EN, 32'h1);
    wr(CMP_HI0, 32'h0);
    wr(MTIME_LO, 32'd1000);
    wr(CMP_LO0, 32'd1020);
    step(19);
    check("ch0_pre_edge", intr, 0);
    step(1);
    check("ch0_rise", intr, 1);
    wr(INTR_ST, 32'h1);
    check("ch0_set_beats_w1c", intr, 1);
    rd(INTR_ST);
    check("ch0_state", rsp_data, 32'h1);
    wr(CMP_HI0, 32'hFFFF_FFFF);
    check("ch0_cmpwr_keeps", intr, 1);
    wr(INTR_ST, 32'h1);
    check("ch0_cleared", intr, 0);

    // Periodic channel 1, period 16
    wr(PERIOD1, 32'd16);
    wr(INTR_EN, 32'h2);
    wr(CMP_HI1, 32'h0);
    wr(MTIME_LO, 32'd2000);
    wr(CMP_LO1, 32'd2005);
    step(4);
    check("ch1_pre_edge", intr, 0);
    step(1);
    check("ch1_rise", intr, 1);
    rd(CMP_LO1);
    check("ch1_cmp_reload1", rsp_data, 32'd2021);
    wr(INTR_ST, 32'h2);
    check("ch1_w1c1", intr, 0);
    step(13);
    check("ch1_pre_edge2", intr, 0);
    step(1);
    check("ch1_rise2", intr, 1);
    rd(CMP_LO1);
    check("ch1_cmp_reload2", rsp_data, 32'd2037);
    wr(INTR_ST, 32'h2);
    check("ch1_w1c2", intr, 0);
    step(13);
    check("ch1_pre_edge3", intr, 0);
    step(1);
    check("ch1_rise3", intr, 1);
    rd(CMP_LO1);
    check("ch1_cmp_reload3", rsp_data, 32'd2053);

    // mtime carry into the high word
    wr(MTIME_HI, 32'h0);
    wr(MTIME_LO, 32'hFFFF_FFFE);
    step(1);
    rd(MTIME_HI);
    check("carry_hi_before", rsp_data, 0);
    rd(MTIME_HI);
    check("carry_hi_after", rsp_data, 1);
    rd(MTIME_LO);
    check("carry_lo_after", rsp_data, 1);

    // Byte-enable write
    bus(1'b1, CMP_LO2, 32'h0000_AB00, 4'b0010);
    rd(CMP_LO2);
    check("be_cmp_lo2", rsp_data, 32'hFFFF_ABFF);
    rd(CMP_HI2);
    check("be_cmp_hi2", rsp_data, 32'hFFFF_FFFF);

    // Unmapped addresses
    rd(32'h014);
    check("err014_err", rsp_err, 1);
    check("err014_rdata", rsp_data, 0);
    rd(32'h100 + 8 * NumCmp);
    check("errcmpN_err", rsp_err, 1);
    check("errcmpN_rdata", rsp_data, 0);
    rd(32'h3FC);
    check("err3fc_err", rsp_err, 1);
    check("err3fc_rdata", rsp_data, 0);
    wr(32'h014, 32'hFFFF_FFFF);
    check("errwr014_err", rsp_err, 1);
    wr(32'h100 + 8 * NumCmp, 32'h0);
    check("errwrcmp_err", rsp_err, 1);
    wr(32'h200 + 4 * NumCmp, 32'h1);
    check("errwrper_rdata", rsp_data, 0);
    rd(INTR_EN);
    check("ien_unchanged", rsp_data, 32'h2);
    check("ien_rd_err0", rsp_err, 0);
    rd(CMP_LO0);
    check("cmp0_unchanged", rsp_data, 32'd1020);
    rd(PERIOD0);
    check("period0_unchanged", rsp_data, 0);
    wr(INTR_EN, 32'hFFFF_FFFF);
    rd(INTR_EN);
    check("ien_impl_bits", rsp_data, 32'hF);
    wr(INTR_EN, 32'h2);

    // Reset in the middle of a response
    @(negedge clk_i);
    req = 1'b1; we = 1'b0; addr = MTIME_LO; be = 4'hF;
    @(posedge clk_i); #1;
    check("midrst_rvalid_pre", rvalid, 1);
    check("midrst_intr_pre", intr, 1);
    #1 rst_ni = 1'b0;
    #1;
    check("midrst_rvalid", rvalid, 0);
    check("midrst_intr", intr, 0);
    req = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i); rst_ni = 1'b1;

    rd(CTRL);
    check("post_ctrl", rsp_data, 32'h1);
    rd(INTR_EN);
    check("post_ien", rsp_data, 32'hF);
    rd(INTR_ST);
    check("post_ist", rsp_data, 0);
    rd(CMP_LO1);
    check("post_cmp1", rsp_data, 32'hFFFF_FFFF);
    rd(PERIOD1);
    check("post_period1", rsp_data, 0);
    check("post_intr", intr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
